sram_arbiter: RTL and testbench

Sequences the single shared SRAM between the SPI write path and `OUTPUT_COUNT` LED-output read requesters. SPI writes are buffered in a one-entry holding register and always win the next free slot. Reads are granted round-robin, and each read completes with a one-cycle finished strobe to its requester. The block sits between `spi_in` / `apa102_out` instances and the SRAM primitive, which has one cycle of read latency.

---
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between a one-entry buffered SPI write path and
// OUTPUT_COUNT round-robin read requesters; the SRAM has one cycle of read latency.
module sram_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int OUTPUT_COUNT      = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0]              write_address,
    input  logic [DATA_BUS_WIDTH-1:0]                 write_data,
    input  logic                                      write_strobe,
    output logic                                      write_overrun,
    input  logic [OUTPUT_COUNT-1:0]                   read_requests,
    input  logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0] read_addresses,
    output logic [DATA_BUS_WIDTH-1:0]                 read_data,
    output logic [OUTPUT_COUNT-1:0]                   read_finished_strobes,
    output logic [ADDRESS_BUS_WIDTH-1:0]              mem_address,
    output logic [DATA_BUS_WIDTH-1:0]                 mem_data_in,
    output logic                                      mem_write_enable,
    input  logic [DATA_BUS_WIDTH-1:0]                 mem_data_out,
    output logic [1:0]                                state
);
    // Handshake: write_strobe is a one-cycle pulse with no backpressure (lost
    // writes raise write_overrun); a read request is a level held with a stable
    // address until its one-cycle finished strobe, and is dropped a cycle later.
    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int DW = DATA_BUS_WIDTH;
    localparam int N  = OUTPUT_COUNT;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ      = 2'd2,
        READ_WAIT = 2'd3
    } state_t;

    state_t        state_q;
    logic          pend_valid;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] next_grant;
    logic [GW-1:0] cand;
    logic          found;
    logic [N-1:0]  eligible;
    logic [N-1:0]  grant_onehot;
    logic [AW-1:0] addr_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_addr
        assign addr_arr[i] = read_addresses[i*AW +: AW];
    end

    assign state        = state_q;
    assign grant_onehot = N'(1) << grant;
    // The requester just served still shows its request this cycle; skip it.
    assign eligible     = read_requests & ~read_finished_strobes;

    always_comb begin
        found      = 1'b0;
        next_grant = last_grant;
        cand       = '0;
        for (int k = 1; k <= N; k++) begin
            cand = GW'((int'(last_grant) + k) % N);
            if (!found && eligible[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    always_comb begin
        mem_address      = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;
        case (state_q)
            WRITE: begin
                mem_address      = pend_addr;
                mem_data_in      = pend_data;
                mem_write_enable = 1'b1;
            end
            READ:    mem_address = addr_arr[grant];
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q               <= IDLE;
            pend_valid            <= 1'b0;
            pend_addr             <= '0;
            pend_data             <= '0;
            write_overrun         <= 1'b0;
            read_data             <= '0;
            read_finished_strobes <= '0;
            grant                 <= '0;
            last_grant            <= GW'(N - 1);
        end else begin
            read_finished_strobes <= '0;

            // The buffer only frees up in the WRITE cycle, so a strobe landing
            // on a full buffer at any other time is lost.
            if (write_strobe) begin
                if (pend_valid && state_q != WRITE) begin
                    write_overrun <= 1'b1;
                end else begin
                    pend_addr  <= write_address;
                    pend_data  <= write_data;
                    pend_valid <= 1'b1;
                end
            end else if (state_q == WRITE) begin
                pend_valid <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pend_valid) begin
                        state_q <= WRITE;
                    end else if (found) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state_q    <= READ;
                    end
                end
                WRITE: state_q <= IDLE;
                READ:  state_q <= READ_WAIT;
                READ_WAIT: begin
                    read_data             <= mem_data_out;
                    read_finished_strobes <= grant_onehot;
                    state_q               <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized read
// bursts checked against a round-robin / memory-contents reference model.
module tb_sram_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   write_address = '0;
    logic [DW-1:0]   write_data = '0;
    logic            write_strobe = 1'b0;
    logic            write_overrun;
    logic [N-1:0]    read_requests = '0;
    logic [N*AW-1:0] read_addresses = '0;
    logic [DW-1:0]   read_data;
    logic [N-1:0]    read_finished_strobes;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data_in;
    logic            mem_write_enable;
    logic [DW-1:0]   mem_data_out;
    logic [1:0]      state;

    // clock / reset
    always #5 clk = ~clk;

    sram_arbiter #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .OUTPUT_COUNT(N)) dut (
        .clk(clk), .rst(rst),
        .write_address(write_address), .write_data(write_data),
        .write_strobe(write_strobe), .write_overrun(write_overrun),
        .read_requests(read_requests), .read_addresses(read_addresses),
        .read_data(read_data), .read_finished_strobes(read_finished_strobes),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
        .state(state)
    );

    // SRAM: one cycle read latency; contents default to addr+1 after reset.
    logic [DW-1:0] sram [0:4095];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) sram[12'(i)] <= DW'(i + 1);
        end else if (mem_write_enable) begin
            sram[mem_address[11:0]] <= mem_data_in;
        end
        mem_data_out <= sram[mem_address[11:0]];
    end

    // scoreboard and reference model
    int            tests = 0;
    int            fails = 0;
    int            rr_last = N - 1;
    logic [DW-1:0] exp_q[$];
    int            exp_idx_q[$];
    logic [DW-1:0] exp_mem [int];
    logic [AW-1:0] addr_tab [N];

    function automatic logic [DW-1:0] mem_value(input logic [AW-1:0] a);
        if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
        return DW'(a + 1);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = mask >> ((last + k) % N);
            if (sh[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_addrs();
        read_addresses = {addr_tab[2], addr_tab[1], addr_tab[0]};
    endtask

    task automatic pulse_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_address = a;
        write_data    = d;
        write_strobe  = 1'b1;
        tick();
        write_strobe  = 1'b0;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        write_strobe  = 1'b0;
        read_requests = '0;
        tick();
        tick();
        rst     = 1'b0;
        rr_last = N - 1;
        exp_mem.delete();
    endtask

    task automatic test_reset();
        int stray;
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if ({state, read_finished_strobes, read_data, write_overrun, mem_write_enable, mem_address, mem_data_in} !== '0) begin
            fails++;
            $display("FAIL reset_values got state=%0d strb=%b rd=%h ovr=%b we=%b ma=%h md=%h exp all zero",
                     state, read_finished_strobes, read_data, write_overrun, mem_write_enable, mem_address, mem_data_in);
        end
        rst = 1'b0;
        addr_tab = '{16'h0050, 16'h0060, 16'h0070};
        load_addrs();
        read_requests = 3'b001;
        repeat (3) tick();
        tests++;
        if (read_finished_strobes !== 3'b001 || read_data !== 16'h0051) begin
            fails++;
            $display("FAIL first_read got strb=%b rd=%h exp strb=001 rd=0051", read_finished_strobes, read_data);
        end
        read_requests = '0;
        tick();
        tick();
        read_requests = 3'b001;
        tick();
        tick();
        tests++;
        if (state !== 2'd3) begin
            fails++;
            $display("FAIL in_read_wait got state=%0d exp 3", state);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({state, read_finished_strobes, read_data, mem_write_enable, mem_address} !== '0) begin
            fails++;
            $display("FAIL async_reset_read got state=%0d strb=%b rd=%h we=%b ma=%h exp all zero",
                     state, read_finished_strobes, read_data, mem_write_enable, mem_address);
        end
        tick();
        tick();
        read_requests = '0;
        rst = 1'b0;
        rr_last = N - 1;
        exp_mem.delete();
        stray = 0;
        repeat (6) begin
            tick();
            if (read_finished_strobes !== '0) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL strobe_after_reset got %0d strobes exp 0", stray);
        end
        pulse_write(16'h0077, 16'h1234);
        tick();
        tests++;
        if (mem_write_enable !== 1'b1) begin
            fails++;
            $display("FAIL write_before_reset got we=%b exp 1", mem_write_enable);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({state, mem_write_enable, mem_address, mem_data_in} !== '0) begin
            fails++;
            $display("FAIL async_reset_write got state=%0d we=%b ma=%h md=%h exp all zero",
                     state, mem_write_enable, mem_address, mem_data_in);
        end
        tick();
        tick();
        rst = 1'b0;
        rr_last = N - 1;
        exp_mem.delete();
        repeat (2) tick();
    endtask

    task automatic test_single_write();
        pulse_write(16'h0123, 16'hBEEF);
        tests++;
        if (mem_write_enable !== 1'b0) begin
            fails++;
            $display("FAIL write_early got we=%b exp 0", mem_write_enable);
        end
        tick();
        tests++;
        if ({mem_write_enable, mem_address, mem_data_in} !== {1'b1, 16'h0123, 16'hBEEF}) begin
            fails++;
            $display("FAIL write_slot got we=%b ma=%h md=%h exp we=1 ma=0123 md=beef",
                     mem_write_enable, mem_address, mem_data_in);
        end
        tick();
        tests++;
        if (mem_write_enable !== 1'b0) begin
            fails++;
            $display("FAIL write_one_cycle got we=%b exp 0", mem_write_enable);
        end
        exp_mem[16'h0123] = 16'hBEEF;
        tick();
    endtask

    task automatic test_round_robin();
        int cyc, got, last_cyc, ei;
        logic [DW-1:0] ed;
        addr_tab = '{16'h0010, 16'h0020, 16'h0030};
        load_addrs();
        for (int j = 0; j < 6; j++) begin
            exp_idx_q.push_back(j % 3);
            exp_q.push_back(16'h0011 + DW'((j % 3) * 16));
        end
        read_requests = 3'b111;
        cyc = 0; got = 0; last_cyc = 0;
        while (got < 6 && cyc < 40) begin
            tick();
            cyc++;
            if (read_finished_strobes !== '0) begin
                ei = exp_idx_q.pop_front();
                ed = exp_q.pop_front();
                tests++;
                if (read_finished_strobes !== onehot(ei)) begin
                    fails++;
                    $display("FAIL rr_order got %b exp %b", read_finished_strobes, onehot(ei));
                end
                tests++;
                if (read_data !== ed) begin
                    fails++;
                    $display("FAIL rr_data got %h exp %h", read_data, ed);
                end
                tests++;
                if (cyc - last_cyc != 3) begin
                    fails++;
                    $display("FAIL rr_spacing got %0d exp 3", cyc - last_cyc);
                end
                last_cyc = cyc;
                got++;
                if (got == 6) read_requests = '0;
            end
        end
        tests++;
        if (got != 6) begin
            fails++;
            $display("FAIL rr_count got %0d exp 6", got);
        end
        read_requests = '0;
        rr_last = 2;
        exp_q.delete();
        exp_idx_q.delete();
        repeat (6) tick();
    endtask

    task automatic test_write_priority();
        int a, b, c, ei;
        logic [N-1:0]  es;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        a  = rr_pick(3'b111, rr_last);
        b  = rr_pick(3'b111, a);
        c  = rr_pick(3'b111, b);
        wa = 16'h0040;
        wd = DW'($urandom);
        read_requests = 3'b111;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            tick();
            ei = (cyc == 3) ? a : (cyc == 6) ? b : (cyc == 11) ? c : -1;
            es = (ei < 0) ? '0 : onehot(ei);
            tests++;
            if (read_finished_strobes !== es) begin
                fails++;
                $display("FAIL prio_strobe cyc%0d got %b exp %b", cyc, read_finished_strobes, es);
            end
            if (ei >= 0) begin
                tests++;
                if (read_data !== mem_value(addr_tab[ei])) begin
                    fails++;
                    $display("FAIL prio_data cyc%0d got %h exp %h", cyc, read_data, mem_value(addr_tab[ei]));
                end
            end
            tests++;
            if (mem_write_enable !== (cyc == 7)) begin
                fails++;
                $display("FAIL prio_we cyc%0d got %b exp %b", cyc, mem_write_enable, cyc == 7);
            end
            if (cyc == 4) begin
                tests++;
                if (mem_address !== addr_tab[b]) begin
                    fails++;
                    $display("FAIL prio_read_addr got %h exp %h", mem_address, addr_tab[b]);
                end
                write_address = wa;
                write_data    = wd;
                write_strobe  = 1'b1;
            end
            if (cyc == 5) write_strobe = 1'b0;
            if (cyc == 7) begin
                tests++;
                if (mem_address !== wa || mem_data_in !== wd) begin
                    fails++;
                    $display("FAIL prio_write got ma=%h md=%h exp ma=%h md=%h", mem_address, mem_data_in, wa, wd);
                end
            end
            if (cyc == 11) read_requests = '0;
        end
        read_requests = '0;
        rr_last = c;
        exp_mem[int'(wa)] = wd;
        repeat (6) tick();
    endtask

    task automatic test_overrun();
        logic [AW-1:0] w1a, w2a, ra;
        logic [DW-1:0] w1d, w2d;
        w1a = 16'h0009; w1d = DW'($urandom);
        w2a = 16'h000A; w2d = DW'($urandom);
        addr_tab[1] = 16'h0008;
        load_addrs();
        read_requests = 3'b010;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            tests++;
            if (read_finished_strobes !== ((cyc == 3) ? 3'b010 : 3'b000)) begin
                fails++;
                $display("FAIL ovr_strobe cyc%0d got %b", cyc, read_finished_strobes);
            end
            tests++;
            if (write_overrun !== (cyc >= 4)) begin
                fails++;
                $display("FAIL ovr_flag cyc%0d got %b exp %b", cyc, write_overrun, cyc >= 4);
            end
            tests++;
            if (mem_write_enable !== (cyc == 4)) begin
                fails++;
                $display("FAIL ovr_we cyc%0d got %b exp %b", cyc, mem_write_enable, cyc == 4);
            end
            if (cyc == 4) begin
                tests++;
                if (mem_address !== w1a || mem_data_in !== w1d) begin
                    fails++;
                    $display("FAIL ovr_first_write got ma=%h md=%h exp ma=%h md=%h", mem_address, mem_data_in, w1a, w1d);
                end
            end
            if (cyc == 1) begin
                write_address = w1a; write_data = w1d; write_strobe = 1'b1;
            end
            if (cyc == 2) write_strobe = 1'b0;
            if (cyc == 3) begin
                write_address = w2a; write_data = w2d; write_strobe = 1'b1;
                read_requests = '0;
            end
            if (cyc == 4) write_strobe = 1'b0;
        end
        rr_last = 1;
        exp_mem[int'(w1a)] = w1d;
        for (int r = 0; r < 2; r++) begin
            ra = (r == 0) ? w2a : w1a;
            addr_tab[0] = ra;
            load_addrs();
            read_requests = 3'b001;
            repeat (3) tick();
            tests++;
            if (read_finished_strobes !== 3'b001 || read_data !== mem_value(ra)) begin
                fails++;
                $display("FAIL ovr_readback addr %h got strb=%b rd=%h exp strb=001 rd=%h",
                         ra, read_finished_strobes, read_data, mem_value(ra));
            end
            read_requests = '0;
            repeat (3) tick();
        end
        rr_last = 0;
        tests++;
        if (write_overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_sticky got %b exp 1", write_overrun);
        end
        apply_reset();
        tests++;
        if (write_overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_cleared got %b exp 0", write_overrun);
        end
        tick();
    endtask

    task automatic test_masking();
        addr_tab[0] = 16'h0015;
        load_addrs();
        read_requests = 3'b001;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            tests++;
            if (read_finished_strobes !== ((cyc == 3) ? 3'b001 : 3'b000)) begin
                fails++;
                $display("FAIL mask_strobe cyc%0d got %b", cyc, read_finished_strobes);
            end
            if (cyc == 3) begin
                tests++;
                if (read_data !== mem_value(16'h0015)) begin
                    fails++;
                    $display("FAIL mask_data got %h exp %h", read_data, mem_value(16'h0015));
                end
            end
            if (cyc == 4) read_requests = '0;
        end
        rr_last = 0;
    endtask

    task automatic test_random();
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, ed;
        logic [N-1:0]  mask;
        int k, last, cyc, got, prev, last_cyc, ei, exp_at, stray;
        for (int burst = 0; burst < 16; burst++) begin
            if ($urandom_range(0, 1) == 1) begin
                wa = AW'($urandom_range(0, 31));
                wd = DW'($urandom);
                pulse_write(wa, wd);
                tick();
                tests++;
                if ({mem_write_enable, mem_address, mem_data_in} !== {1'b1, wa, wd}) begin
                    fails++;
                    $display("FAIL rnd_write got we=%b ma=%h md=%h exp we=1 ma=%h md=%h",
                             mem_write_enable, mem_address, mem_data_in, wa, wd);
                end
                exp_mem[int'(wa)] = wd;
                tick();
                tick();
            end
            mask = N'($urandom_range(1, 7));
            k    = $urandom_range(1, 5);
            for (int i = 0; i < N; i++) addr_tab[i] = AW'($urandom_range(0, 31));
            load_addrs();
            last = rr_last;
            for (int j = 0; j < k; j++) begin
                last = rr_pick(mask, last);
                exp_idx_q.push_back(last);
                exp_q.push_back(mem_value(addr_tab[last]));
            end
            read_requests = mask;
            cyc = 0; got = 0; prev = -1; last_cyc = 0;
            while (got < k && cyc < 40) begin
                tick();
                cyc++;
                if (read_finished_strobes !== '0) begin
                    ei = exp_idx_q.pop_front();
                    ed = exp_q.pop_front();
                    exp_at = (prev < 0) ? 3 : last_cyc + ((ei == prev) ? 4 : 3);
                    tests++;
                    if (read_finished_strobes !== onehot(ei)) begin
                        fails++;
                        $display("FAIL rnd_grant got %b exp %b", read_finished_strobes, onehot(ei));
                    end
                    tests++;
                    if (read_data !== ed) begin
                        fails++;
                        $display("FAIL rnd_data got %h exp %h", read_data, ed);
                    end
                    tests++;
                    if (cyc != exp_at) begin
                        fails++;
                        $display("FAIL rnd_timing got cyc%0d exp cyc%0d", cyc, exp_at);
                    end
                    prev = ei;
                    last_cyc = cyc;
                    got++;
                    if (got == k) read_requests = '0;
                end
            end
            tests++;
            if (got != k) begin
                fails++;
                $display("FAIL rnd_count got %0d exp %0d", got, k);
            end
            read_requests = '0;
            rr_last = last;
            exp_q.delete();
            exp_idx_q.delete();
            stray = 0;
            repeat (5) begin
                tick();
                if (read_finished_strobes !== '0) stray++;
            end
            tests++;
            if (stray != 0) begin
                fails++;
                $display("FAIL rnd_extra got %0d strobes exp 0", stray);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got no finish exp finish before 400000");
        $fatal(1, "watchdog");
    end

    // final report
    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_write_priority();
        test_overrun();
        test_masking();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
